// File: rtl/mfp_rojobot_emu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mfp_rojobot_emu_pkg: motion/orient codes, sensor bits, BOT_INFO    |
// | layout shared with the AHB I/O peripheral.            Rev 1.0      |
// +--------------------------------------------------------------------+
package mfp_rojobot_emu_pkg;

  typedef enum logic [3:0] {
    MOT_STOP  = 4'd0,
    MOT_FWD   = 4'd1,
    MOT_REV   = 4'd2,
    MOT_LEFT  = 4'd3,
    MOT_RIGHT = 4'd4
  } motion_e;

  localparam logic [2:0] ORIENT_N  = 3'd0;
  localparam logic [2:0] ORIENT_NE = 3'd1;
  localparam logic [2:0] ORIENT_E  = 3'd2;
  localparam logic [2:0] ORIENT_SE = 3'd3;
  localparam logic [2:0] ORIENT_S  = 3'd4;
  localparam logic [2:0] ORIENT_SW = 3'd5;
  localparam logic [2:0] ORIENT_W  = 3'd6;
  localparam logic [2:0] ORIENT_NW = 3'd7;

  localparam int SNS_XBLK = 0;
  localparam int SNS_YBLK = 1;
  localparam int SNS_OVR  = 2;
  localparam int SNS_ILL  = 3;

  // Field order fixes the bit positions of the 32-bit info word.
  typedef struct packed {
    logic [7:0] loc_x;
    logic [7:0] loc_y;
    logic [7:0] sensors;
    logic [2:0] orient;
    logic       rsvd;
    motion_e    motion;
  } bot_info_t;

  typedef struct packed {
    logic xp;
    logic xn;
    logic yp;
    logic yn;
  } step_t;

  function automatic step_t orient_step(input logic [2:0] orient);
    step_t s;
    s = '0;
    case (orient)
      ORIENT_N:  s.yp = 1'b1;
      ORIENT_NE: begin s.xp = 1'b1; s.yp = 1'b1; end
      ORIENT_E:  s.xp = 1'b1;
      ORIENT_SE: begin s.xp = 1'b1; s.yn = 1'b1; end
      ORIENT_S:  s.yn = 1'b1;
      ORIENT_SW: begin s.xn = 1'b1; s.yn = 1'b1; end
      ORIENT_W:  s.xn = 1'b1;
      default:   begin s.xn = 1'b1; s.yp = 1'b1; end
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mfp_rojobot_motion_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mfp_rojobot_motion_decode: motor command byte to motion code.      |
// |                                                       Rev 1.0      |
// +--------------------------------------------------------------------+
module mfp_rojobot_motion_decode
  import mfp_rojobot_emu_pkg::*;
(
  input  logic [7:0] ctrl_i,
  output motion_e    motion_o,
  output logic       illegal_o
);

  logic l_on_w;
  logic r_on_w;
  logic l_fwd_w;
  logic r_fwd_w;

  assign l_on_w  = |ctrl_i[6:4];
  assign r_on_w  = |ctrl_i[2:0];
  assign l_fwd_w = ctrl_i[7];
  assign r_fwd_w = ctrl_i[3];

  always_comb begin
    motion_o  = MOT_STOP;
    illegal_o = 1'b0;
    if (l_on_w ^ r_on_w) begin
      illegal_o = 1'b1;
    end else if (l_on_w && r_on_w) begin
      case ({l_fwd_w, r_fwd_w})
        2'b11:   motion_o = MOT_FWD;
        2'b00:   motion_o = MOT_REV;
        2'b01:   motion_o = MOT_LEFT;
        default: motion_o = MOT_RIGHT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mfp_rojobot_emu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mfp_rojobot_emu: tick-driven robot position/orient emulator with   |
// | update handshake to the AHB I/O peripheral.           Rev 1.0      |
// +--------------------------------------------------------------------+
module mfp_rojobot_emu
  import mfp_rojobot_emu_pkg::*;
#(
  parameter int UPDATE_DIV = 1000000,
  parameter int WORLD_MAX  = 127
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [7:0]  H_BOT_CTRL,
  input  logic        H_INT_ACK,
  output logic [31:0] H_BOT_INFO,
  output logic        H_BOT_UPDATE_SYNC
);

  localparam int               CNT_W    = 25;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(UPDATE_DIV - 1);
  localparam logic [7:0]       C_MAX    = 8'(WORLD_MAX);
  localparam logic [7:0]       C_HOME   = 8'(WORLD_MAX / 2);

  logic [CNT_W-1:0] div_q, div_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic [2:0]       orient_q, orient_d;
  motion_e          motion_q, motion_d;
  logic             xblk_q, xblk_d;
  logic             yblk_q, yblk_d;
  logic             ovr_q, ovr_d;
  logic             ill_q, ill_d;
  logic             sync_q, sync_d;

  logic             tick_w;
  motion_e          motion_w;
  logic             illegal_w;
  step_t            step_w;
  logic             x_up_w, x_dn_w, y_up_w, y_dn_w;
  logic             x_blk_w, y_blk_w;
  logic [7:0]       sensors_w;
  bot_info_t        info_w;

  mfp_rojobot_motion_decode u_decode (
    .ctrl_i    (H_BOT_CTRL),
    .motion_o  (motion_w),
    .illegal_o (illegal_w)
  );

  assign tick_w = (div_q == DIV_LAST);
  assign step_w = orient_step(orient_q);

  // Reverse travel uses the opposite direction of each axis component.
  assign x_up_w = ((motion_w == MOT_FWD) && step_w.xp) || ((motion_w == MOT_REV) && step_w.xn);
  assign x_dn_w = ((motion_w == MOT_FWD) && step_w.xn) || ((motion_w == MOT_REV) && step_w.xp);
  assign y_up_w = ((motion_w == MOT_FWD) && step_w.yp) || ((motion_w == MOT_REV) && step_w.yn);
  assign y_dn_w = ((motion_w == MOT_FWD) && step_w.yn) || ((motion_w == MOT_REV) && step_w.yp);

  assign x_blk_w = (x_up_w && (x_q == C_MAX)) || (x_dn_w && (x_q == 8'd0));
  assign y_blk_w = (y_up_w && (y_q == C_MAX)) || (y_dn_w && (y_q == 8'd0));

  always_comb begin
    div_d    = tick_w ? '0 : div_q + CNT_W'(1);
    x_d      = x_q;
    y_d      = y_q;
    orient_d = orient_q;
    motion_d = motion_q;
    xblk_d   = xblk_q;
    yblk_d   = yblk_q;
    ill_d    = ill_q;
    ovr_d    = ovr_q;
    sync_d   = sync_q;
    if (tick_w) begin
      motion_d = motion_w;
      ill_d    = illegal_w;
      xblk_d   = x_blk_w;
      yblk_d   = y_blk_w;
      if (x_up_w && !x_blk_w) x_d = x_q + 8'd1;
      if (x_dn_w && !x_blk_w) x_d = x_q - 8'd1;
      if (y_up_w && !y_blk_w) y_d = y_q + 8'd1;
      if (y_dn_w && !y_blk_w) y_d = y_q - 8'd1;
      if (motion_w == MOT_LEFT)  orient_d = orient_q - 3'd1;
      if (motion_w == MOT_RIGHT) orient_d = orient_q + 3'd1;
      // A tick beats a same-cycle acknowledge for both flags.
      ovr_d  = ovr_q | sync_q;
      sync_d = 1'b1;
    end else if (H_INT_ACK) begin
      ovr_d  = 1'b0;
      sync_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_q    <= '0;
      x_q      <= C_HOME;
      y_q      <= C_HOME;
      orient_q <= ORIENT_N;
      motion_q <= MOT_STOP;
      xblk_q   <= 1'b0;
      yblk_q   <= 1'b0;
      ill_q    <= 1'b0;
      ovr_q    <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      orient_q <= orient_d;
      motion_q <= motion_d;
      xblk_q   <= xblk_d;
      yblk_q   <= yblk_d;
      ill_q    <= ill_d;
      ovr_q    <= ovr_d;
      sync_q   <= sync_d;
    end
  end

  always_comb begin
    sensors_w           = '0;
    sensors_w[SNS_XBLK] = xblk_q;
    sensors_w[SNS_YBLK] = yblk_q;
    sensors_w[SNS_OVR]  = ovr_q;
    sensors_w[SNS_ILL]  = ill_q;
  end

  assign info_w = '{loc_x: x_q, loc_y: y_q, sensors: sensors_w, orient: orient_q,
                    rsvd: 1'b0, motion: motion_q};

  assign H_BOT_INFO        = info_w;
  assign H_BOT_UPDATE_SYNC = sync_q;

endmodule
`default_nettype wire

// File: tb/tb_mfp_rojobot_emu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mfp_rojobot_emu: table-driven walk plus handshake/reset corner  |
// | sequences, scoreboarded against a behavioural robot model. Rev 1.0 |
// +--------------------------------------------------------------------+
module tb_mfp_rojobot_emu;

  localparam int DIV  = 4;
  localparam int WMAX = 127;

  logic        HCLK;
  logic        HRESETn;
  logic [7:0]  H_BOT_CTRL;
  logic        H_INT_ACK;
  logic [31:0] H_BOT_INFO;
  logic        H_BOT_UPDATE_SYNC;

  mfp_rojobot_emu #(.UPDATE_DIV(DIV), .WORLD_MAX(WMAX)) dut (
    .HCLK              (HCLK),
    .HRESETn           (HRESETn),
    .H_BOT_CTRL        (H_BOT_CTRL),
    .H_INT_ACK         (H_INT_ACK),
    .H_BOT_INFO        (H_BOT_INFO),
    .H_BOT_UPDATE_SYNC (H_BOT_UPDATE_SYNC)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] info;
    logic        sync;
  } exp_t;

  typedef struct {
    logic [7:0] ctrl;
    int         reps;
    int         ex;
    int         ey;
    int         eo;
    int         em;
    logic [7:0] es;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[14];
  int   total = 0;
  int   bad   = 0;
  int   phase = 0;

  // Behavioural model: integer position, heading lookup tables.
  int   mx, my, mo, mm;
  bit   mxb, myb, mill, movr, msync;
  int   dxt[8];
  int   dyt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack();
    return {mx[7:0], my[7:0], 4'b0000, mill, movr, myb, mxb, mo[2:0], 1'b0, mm[3:0]};
  endfunction

  task automatic model_reset();
    mx = WMAX / 2; my = WMAX / 2; mo = 0; mm = 0;
    mxb = 0; myb = 0; mill = 0; movr = 0; msync = 0;
  endtask

  task automatic model_tick(input logic [7:0] c);
    bit lon, ron;
    int sgn, nx, ny;
    lon = (c[6:4] != 3'd0);
    ron = (c[2:0] != 3'd0);
    mill = 0; mxb = 0; myb = 0;
    if (!lon && !ron)      mm = 0;
    else if (lon != ron) begin mm = 0; mill = 1; end
    else if (c[7] && c[3])   mm = 1;
    else if (!c[7] && !c[3]) mm = 2;
    else if (!c[7])          mm = 3;
    else                     mm = 4;
    if (mm == 1 || mm == 2) begin
      sgn = (mm == 1) ? 1 : -1;
      nx = mx + sgn * dxt[mo];
      ny = my + sgn * dyt[mo];
      if (nx < 0 || nx > WMAX) mxb = 1; else mx = nx;
      if (ny < 0 || ny > WMAX) myb = 1; else my = ny;
    end
    if (mm == 3) mo = (mo + 7) % 8;
    if (mm == 4) mo = (mo + 1) % 8;
    movr  = movr | msync;
    msync = 1;
  endtask

  task automatic edge_step();
    @(posedge HCLK);
    #1;
    phase = (phase + 1) % DIV;
  endtask

  // One full tick period; ctrl is scrambled between ticks to show it is only sampled on the tick.
  task automatic do_tick(input logic [7:0] c, input bit ack);
    exp_t        e;
    logic [31:0] prev;
    H_BOT_CTRL = ~c;
    if (ack) begin
      H_INT_ACK = 1'b1;
      movr  = 0;
      msync = 0;
      edge_step();
      H_INT_ACK = 1'b0;
    end
    prev = pack();
    model_tick(c);
    e.info = pack();
    e.sync = msync;
    exp_q.push_back(e);
    while (phase != DIV - 1) edge_step();
    chk("info_stable_between_ticks", H_BOT_INFO, prev);
    H_BOT_CTRL = c;
    edge_step();
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("tick_info", H_BOT_INFO, e.info);
      chk("tick_sync", {31'd0, H_BOT_UPDATE_SYNC}, {31'd0, e.sync});
    end
  endtask

  initial begin
    dxt = '{0, 1, 1, 1, 0, -1, -1, -1};
    dyt = '{1, 1, 0, -1, -1, -1, 0, 1};
    // 8'h99 = both forward, 8'h11 = both reverse, 8'h91 = right turn, 8'h19 = left turn.
    tbl[0]  = '{8'h99,  3,  63, 66, 0, 1, 8'h00};
    tbl[1]  = '{8'h11,  1,  63, 65, 0, 2, 8'h00};
    tbl[2]  = '{8'h91,  9,  63, 65, 1, 4, 8'h00};
    tbl[3]  = '{8'h91,  3,  63, 65, 4, 4, 8'h00};
    tbl[4]  = '{8'h99, 55,  63, 10, 4, 1, 8'h00};
    tbl[5]  = '{8'h19,  2,  63, 10, 2, 3, 8'h00};
    tbl[6]  = '{8'h99, 64, 127, 10, 2, 1, 8'h00};
    tbl[7]  = '{8'h19,  1, 127, 10, 1, 3, 8'h00};
    tbl[8]  = '{8'h99,  1, 127, 11, 1, 1, 8'h01};
    tbl[9]  = '{8'h11,  1, 126, 10, 1, 2, 8'h00};
    tbl[10] = '{8'h10,  1, 126, 10, 1, 0, 8'h08};
    tbl[11] = '{8'h00,  1, 126, 10, 1, 0, 8'h00};
    tbl[12] = '{8'h91,  3, 126, 10, 4, 4, 8'h00};
    tbl[13] = '{8'h99, 11, 126,  0, 4, 1, 8'h02};

    HRESETn    = 1'b0;
    H_BOT_CTRL = 8'h00;
    H_INT_ACK  = 1'b0;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1;
    chk("reset_info", H_BOT_INFO, 32'h3F3F_0000);
    chk("reset_sync", {31'd0, H_BOT_UPDATE_SYNC}, 32'd0);
    HRESETn = 1'b1;
    phase   = 0;

    for (int i = 0; i < 14; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) do_tick(tbl[i].ctrl, 1'b1);
      chk($sformatf("table_%0d", i), H_BOT_INFO,
          {tbl[i].ex[7:0], tbl[i].ey[7:0], tbl[i].es, tbl[i].eo[2:0], 1'b0, tbl[i].em[3:0]});
    end

    // Two unacknowledged ticks raise overrun; one ACK clears both flags.
    do_tick(8'h00, 1'b1);
    do_tick(8'h00, 1'b0);
    chk("overrun_set", {24'd0, H_BOT_INFO[15:8]}, 32'h0000_0004);
    H_INT_ACK = 1'b1;
    edge_step();
    H_INT_ACK = 1'b0;
    movr = 0; msync = 0;
    chk("ack_clears_sync", {31'd0, H_BOT_UPDATE_SYNC}, 32'd0);
    chk("ack_clears_overrun", {31'd0, H_BOT_INFO[10]}, 32'd0);

    // ACK coinciding with a tick: tick wins, next ACK cycle clears.
    do_tick(8'h00, 1'b0);
    while (phase != DIV - 1) edge_step();
    H_INT_ACK = 1'b1;
    model_tick(8'h00);
    edge_step();
    chk("tick_beats_ack_sync", {31'd0, H_BOT_UPDATE_SYNC}, 32'd1);
    chk("tick_beats_ack_ovr", {31'd0, H_BOT_INFO[10]}, 32'd1);
    edge_step();
    H_INT_ACK = 1'b0;
    movr = 0; msync = 0;
    chk("held_ack_clears_sync", {31'd0, H_BOT_UPDATE_SYNC}, 32'd0);
    chk("held_ack_info", H_BOT_INFO, pack());

    // Reset mid-count: outputs return home at once, divider restarts from release.
    do_tick(8'h91, 1'b1);
    edge_step();
    edge_step();
    HRESETn = 1'b0;
    #2;
    chk("midcount_reset_info", H_BOT_INFO, 32'h3F3F_0000);
    chk("midcount_reset_sync", {31'd0, H_BOT_UPDATE_SYNC}, 32'd0);
    edge_step();
    HRESETn = 1'b1;
    phase   = 0;
    model_reset();
    do_tick(8'h99, 1'b0);
    chk("post_reset_first_tick", H_BOT_INFO, 32'h3F40_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
